// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared definitions for the serial program loader: loader FSM
//               state encoding, default frame header and default memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Default number of instruction-memory entries (largest accepted length).
    localparam int MEM_DEPTH_DEF = 24;

    // Default frame start byte.
    localparam logic [7:0] HEADER_DEF = 8'hA5;

    // Width of the instruction-memory write address.
    localparam int ADDR_W = 5;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_8n1
// Description : 8N1 UART receiver. Two-flop synchroniser, falling-edge start
//               detection with mid-bit start re-check, LSB-first data shift,
//               stop-bit check.
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               rx_i         - serial line, idle high, asynchronous to clk
//               byte_valid_o - one-cycle pulse, byte_data_o holds a new byte
//               byte_data_o  - last received byte
//               frame_err_o  - one-cycle pulse, stop bit was sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchroniser plus one history flop for falling-edge detection. All
    // reset high so a reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-bit re-check rejects glitches shorter than half a bit.
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                // A line stuck low yields one error, then nothing until it
                // has returned high.
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule : uart_rx_8n1
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial boot loader. Receives HEADER, LEN, L data bytes (and a
//               mod-256 checksum byte when LOADER_CHECKSUM_EN is defined) over
//               an 8N1 UART line, writes the data into instruction memory and
//               releases the CPU reset only once a complete image is accepted.
// Build macro : LOADER_CHECKSUM_EN - adds the checksum byte and accumulator.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               rx_i        - UART receive line
//               mem_we_o    - one-cycle instruction-memory write strobe
//               mem_addr_o  - write address
//               mem_data_o  - write data
//               cpu_rst_n_o - CPU reset, high only while an image is loaded
//               busy_o      - frame in progress
//               load_done_o - image accepted
//               load_err_o  - last frame rejected
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter logic [7:0] HEADER       = HEADER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_ferr)
    );

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic w_is_header;
    logic w_len_ok;
    logic w_last;

    assign w_is_header = (rx_data == HEADER);
    assign w_len_ok    = (rx_data != 8'd0) && (int'(rx_data) <= MEM_DEPTH);
    assign w_last      = (addr_q == (len_q - ADDR_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && w_is_header) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    if (w_len_ok) begin
                        state_d = ST_DATA;
                        len_d   = rx_data[ADDR_W-1:0];
                        addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = 8'd0;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = rx_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + rx_data;
`endif
                    // The counter stops on the last byte, so no address
                    // beyond L-1 is ever produced.
                    if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (rx_valid && w_is_header) begin
                    state_d = ST_LEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = waddr_q;
    assign mem_data_o  = wdata_q;
    assign cpu_rst_n_o = (state_q == ST_DONE);
    assign load_done_o = (state_q == ST_DONE);
    assign load_err_o  = (state_q == ST_ERR);
    assign busy_o      = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                         (state_q == ST_CSUM);

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A frame-level model
//               tracks the loader's position in the frame protocol and the
//               writes it must make; a compare process checks the status
//               outputs every settled cycle and a monitor checks each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst_n, busy, load_done, load_err;

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .MEM_DEPTH    (24),
        .HEADER       (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .cpu_rst_n_o (cpu_rst_n),
        .busy_o      (busy),
        .load_done_o (load_done),
        .load_err_o  (load_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame-level model: 0 waiting header, 1 expecting length, 2 receiving
    // data, 3 expecting checksum, 4 image accepted, 5 frame rejected.
    int          m_st  = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    logic [7:0]  m_sum = 8'd0;
    logic [12:0] exp_wr[$];
    logic [12:0] wr_log[$];

    bit   chk_en   = 1'b0;
    bit   settling = 1'b0;
    logic prev_we  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] model_vec();
        return {m_st == 4, (m_st >= 1) && (m_st <= 3), m_st == 4, m_st == 5};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        case (m_st)
            0: if (b == 8'hA5) m_st = 1;
            1: begin
                if (b != 8'd0 && b <= 8'd24) begin
                    m_st = 2; m_len = int'(b); m_cnt = 0; m_sum = 8'd0;
                end else begin
                    m_st = 5;
                end
            end
            2: begin
                exp_wr.push_back({m_cnt[4:0], b});
                m_sum = m_sum + b;
                m_cnt++;
                if (m_cnt == m_len) m_st = CK ? 3 : 4;
            end
            3: m_st = (b == m_sum) ? 4 : 5;
            default: if (b == 8'hA5) m_st = 1;
        endcase
    endtask

    task automatic model_ferr();
        if (m_st >= 1 && m_st <= 3) m_st = 5;
    endtask

    // Status outputs on every settled cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n && !settling)
            check("status", {cpu_rst_n, busy, load_done, load_err}, model_vec());
    end

    // Write monitor: order, content, spacing and state timing of each write.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                check("mem_we_spacing", prev_we, 0);
                wr_log.push_back({mem_addr, mem_data});
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                             mem_addr, mem_data);
                end else begin
                    check("write", {mem_addr, mem_data}, exp_wr.pop_front());
                end
                check("status_at_write", {cpu_rst_n, busy, load_done, load_err}, model_vec());
            end
            prev_we = mem_we;
        end
    end

    task automatic send_bits(input logic [7:0] b);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        send_bits(b);
        settling = 1'b1;
        if (stop) model_byte(b);
        else      model_ferr();
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        settling = 1'b0;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input bit good_sum);
        logic [7:0] s;
        logic [7:0] d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        s = 8'd0;
        send_byte(8'hA5, 1);
        send_byte(len, 1);
        for (int i = 0; i < int'(len) && i < 3; i++) begin
            send_byte(d[i], 1);
            s = s + d[i];
        end
        if (CK) send_byte(good_sum ? s : ~s, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;
        int         len, kind, cut;

        // Reset state.
        repeat (5) @(negedge clk);
        check("reset_outputs", {mem_we, mem_addr, mem_data, cpu_rst_n, busy, load_done, load_err}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Three-byte image.
        wr_log.delete();
        send_frame(8'd3, 8'h01, 8'h2A, 8'h0A, 1);
        check("t1_nwrites", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("t1_w0", wr_log[0], 13'h001);
            check("t1_w1", wr_log[1], 13'h12A);
            check("t1_w2", wr_log[2], 13'h20A);
        end
        check("t1_done", {load_done, cpu_rst_n, load_err}, 3'b110);

        // Wrong checksum (FF instead of 33).
        send_byte(8'hA5, 1); send_byte(8'h02, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'hFF, 1);
        check("t2_result", {load_done, cpu_rst_n, load_err}, CK ? 3'b001 : 3'b110);

        // Illegal lengths write nothing.
        wr_log.delete();
        send_byte(8'hA5, 1); send_byte(8'h00, 1);
        check("t3_len0", {busy, load_err}, 2'b01);
        send_byte(8'hA5, 1); send_byte(8'h19, 1);
        check("t3_len25", {busy, load_err}, 2'b01);
        check("t3_nwrites", wr_log.size(), 0);

        // Leading junk ignored, single write.
        wr_log.delete();
        send_byte(8'h3C, 1); send_byte(8'h00, 1);
        send_byte(8'hA5, 1); send_byte(8'h01, 1);
        send_byte(8'h07, 1); send_byte(8'h07, 1);
        check("t4_nwrites", wr_log.size(), 1);
        if (wr_log.size() == 1) check("t4_w0", wr_log[0], 13'h007);
        check("t4_done", {load_done, cpu_rst_n}, 2'b11);

        // Restart from DONE, with a start-bit glitch in the LEN state.
        send_byte(8'hA5, 1);
        check("t5_restart", {cpu_rst_n, busy, load_done}, 3'b010);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h02, 1); send_byte(8'h5A, 1); send_byte(8'h5B, 1);
        if (CK) send_byte(8'hB5, 1);
        check("t5_done", {load_done, cpu_rst_n}, 2'b11);

        // Framing error mid-DATA.
        send_byte(8'hA5, 1); send_byte(8'h04, 1);
        send_byte(8'h10, 1); send_byte(8'h20, 1);
        send_byte(8'h30, 0);
        check("t6_ferr", {load_err, busy, cpu_rst_n}, 3'b100);

        // Asynchronous reset mid-DATA, then a clean load.
        send_byte(8'hA5, 1); send_byte(8'h05, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        @(negedge clk) rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("t7_busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1 check("t7_reset_outputs",
                 {mem_we, mem_addr, mem_data, cpu_rst_n, busy, load_done, load_err}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        m_st = 0;
        exp_wr.delete();
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'd2, 8'hC3, 8'h3C, 8'h00, 1);
        check("t7_reload", {load_done, cpu_rst_n, load_err}, 3'b110);

        // Line held low while DONE: one ignored error, then re-arm on high.
        @(negedge clk) rx = 1'b0;
        repeat (25 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t8_still_done", {load_done, cpu_rst_n, load_err}, 3'b110);
        send_frame(8'd1, 8'h99, 8'h00, 8'h00, 1);
        check("t8_rearm", {load_done, cpu_rst_n, busy}, 3'b110);

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            q.delete();
            if ($urandom_range(0, 2) == 0) q.push_back(8'($urandom));
            q.push_back(8'hA5);
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(25, 255)));
                foreach (q[i]) send_byte(q[i], 1);
            end else begin
                len = $urandom_range(1, 24);
                q.push_back(8'(len));
                s = 8'd0;
                for (int i = 0; i < len; i++) begin
                    q.push_back(8'($urandom));
                    s = s + q[q.size() - 1];
                end
                if (CK) q.push_back((kind == 2) ? s + 8'($urandom_range(1, 255)) : s);
                if (kind == 1) begin
                    cut = $urandom_range(q.size() - len, q.size() - 1);
                    for (int i = 0; i < cut; i++) send_byte(q[i], 1);
                    send_byte(8'($urandom), 0);
                end else begin
                    foreach (q[i]) send_byte(q[i], 1);
                end
            end
        end

        check("pending_writes", exp_wr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
